mem_access_controller: RTL and testbench

MEM_ACCESS_CONTROLLER -- requirements
Module: mem_access_controller

---
 rtl/mem_ctrl_pkg.sv | 19 +
 rtl/mem_access_controller_if.sv | 49 ++++
 rtl/mem_req_arbiter.sv | 40 ++++
 rtl/mem_access_controller.sv | 145 ++++++++++++++
 tb/tb_mem_access_controller.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the memory access controller: FSM encoding,
// access-size codes and the default starvation limit.
package mem_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      ACC0 = 3'd1,
      ACC1 = 3'd2,
      LAST = 3'd3,
      RESP = 3'd4
   } state_t;

   // a_nbytes encoding: 01 is a single byte, anything else is a 16-bit word
   localparam logic [1:0] NB_BYTE = 2'b01;
   localparam logic [1:0] NB_WORD = 2'b10;

   localparam int STARVE_LIMIT_DEF = 4;

endpackage

// File: rtl/mem_access_controller_if.sv
// Bus bundle for the memory access controller: A requester (MEM stage),
// B requester (loader) and the byte-wide memory port.
interface mem_access_controller_if #(
   parameter int ADDR_W = 16
);
   // A port
   logic              a_req;
   logic              a_wr;
   logic [1:0]        a_nbytes;
   logic [ADDR_W-1:0] a_addr;
   logic [15:0]       a_wdata;
   logic              a_ready;
   logic [15:0]       a_rdata;
   logic              a_stall;
   // B port
   logic              b_req;
   logic              b_wr;
   logic [ADDR_W-1:0] b_addr;
   logic [15:0]       b_wdata;
   logic              b_ready;
   logic [15:0]       b_rdata;
   // memory port
   logic [ADDR_W-1:0] mem_addr;
   logic [7:0]        mem_wdata;
   logic              mem_we;
   logic              mem_re;
   logic [7:0]        mem_rdata;

   // controller side
   modport slave (
      input  a_req, a_wr, a_nbytes, a_addr, a_wdata,
      output a_ready, a_rdata, a_stall,
      input  b_req, b_wr, b_addr, b_wdata,
      output b_ready, b_rdata,
      output mem_addr, mem_wdata, mem_we, mem_re,
      input  mem_rdata
   );

   // requesters plus memory device side
   modport master (
      output a_req, a_wr, a_nbytes, a_addr, a_wdata,
      input  a_ready, a_rdata, a_stall,
      output b_req, b_wr, b_addr, b_wdata,
      input  b_ready, b_rdata,
      input  mem_addr, mem_wdata, mem_we, mem_re,
      output mem_rdata
   );

endinterface

// File: rtl/mem_req_arbiter.sv
// Fixed-priority arbiter (A over B) with a starvation counter that forces a
// B grant after STARVE_LIMIT consecutive A grants while B is waiting.
module mem_req_arbiter
   import mem_ctrl_pkg::*;
#(
   parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
   input  logic clk,
   input  logic reset,
   input  logic i_idle,
   input  logic i_a_req,
   input  logic i_b_req,
   output logic o_gnt_vld,
   output logic o_gnt_b
);

   localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

   logic [CNT_W-1:0] r_cnt;
   logic             w_starved;

   assign w_starved = (r_cnt == LIMIT);
   assign o_gnt_vld = i_idle & (i_a_req | i_b_req);
   assign o_gnt_b   = i_idle & i_b_req & (~i_a_req | w_starved);

   // Count A grants that overtake a waiting B; clear once B is served or gone.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt <= '0;
      end else if (i_idle) begin
         if (!i_b_req || o_gnt_b) begin
            r_cnt <= '0;
         end else if (i_a_req && !w_starved) begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/mem_access_controller.sv
// Two-port memory access controller: arbitrates A and B requests onto a
// byte-wide single-port memory, splitting words into two byte cycles.
module mem_access_controller
   import mem_ctrl_pkg::*;
#(
   parameter int ADDR_W       = 16,
   parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
   input logic                    clk,
   input logic                    reset,
   mem_access_controller_if.slave bus
);

   state_t            r_state;
   state_t            w_next;
   logic              r_is_b;
   logic              r_wr;
   logic              r_word;
   logic [ADDR_W-1:0] r_addr;
   logic [15:0]       r_wdata;
   logic [7:0]        r_rd_lo;
   logic              r_a_ready;
   logic              r_b_ready;
   logic [15:0]       r_a_rdata;
   logic [15:0]       r_b_rdata;
   logic              w_idle;
   logic              w_gnt_vld;
   logic              w_gnt_b;
   logic [15:0]       w_rd_word;
   logic [ADDR_W-1:0] w_mem_addr;
   logic [7:0]        w_mem_wdata;
   logic              w_mem_we;
   logic              w_mem_re;

   assign w_idle = (r_state == IDLE);

   mem_req_arbiter #(
      .STARVE_LIMIT(STARVE_LIMIT)
   ) u_arb (
      .clk      (clk),
      .reset    (reset),
      .i_idle   (w_idle),
      .i_a_req  (bus.a_req),
      .i_b_req  (bus.b_req),
      .o_gnt_vld(w_gnt_vld),
      .o_gnt_b  (w_gnt_b)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_next;
   end

   // Next state and memory strobes; memory side is quiet outside ACC0/ACC1.
   always_comb begin
      w_next      = r_state;
      w_mem_addr  = '0;
      w_mem_wdata = '0;
      w_mem_we    = 1'b0;
      w_mem_re    = 1'b0;
      case (r_state)
         IDLE: if (w_gnt_vld) w_next = ACC0;
         ACC0: begin
            w_mem_addr  = r_addr;
            w_mem_wdata = r_wdata[7:0];
            w_mem_we    = r_wr;
            w_mem_re    = ~r_wr;
            w_next      = r_word ? ACC1 : LAST;
         end
         ACC1: begin
            w_mem_addr  = r_addr + ADDR_W'(1);
            w_mem_wdata = r_wdata[15:8];
            w_mem_we    = r_wr;
            w_mem_re    = ~r_wr;
            w_next      = LAST;
         end
         LAST:    w_next = RESP;
         RESP:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   // Latch the winning request at the grant edge; B is always a word.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_is_b  <= 1'b0;
         r_wr    <= 1'b0;
         r_word  <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
      end else if (w_idle && w_gnt_vld) begin
         r_is_b <= w_gnt_b;
         if (w_gnt_b) begin
            r_wr    <= bus.b_wr;
            r_word  <= 1'b1;
            r_addr  <= bus.b_addr;
            r_wdata <= bus.b_wdata;
         end else begin
            r_wr    <= bus.a_wr;
            r_word  <= (bus.a_nbytes != NB_BYTE);
            r_addr  <= bus.a_addr;
            r_wdata <= bus.a_wdata;
         end
      end
   end

   // Read data arrives one cycle after its address: low byte is on the bus
   // in ACC1 (word) or LAST (byte), high byte in LAST (word).
   assign w_rd_word = r_word ? {bus.mem_rdata, r_rd_lo} : {8'h00, bus.mem_rdata};

   // Collect read bytes and raise the granted port's ready for the RESP cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_rd_lo   <= '0;
         r_a_ready <= 1'b0;
         r_b_ready <= 1'b0;
         r_a_rdata <= '0;
         r_b_rdata <= '0;
      end else begin
         r_a_ready <= 1'b0;
         r_b_ready <= 1'b0;
         if (r_state == ACC1) r_rd_lo <= bus.mem_rdata;
         if (r_state == LAST) begin
            if (r_is_b) r_b_ready <= 1'b1;
            else        r_a_ready <= 1'b1;
            if (!r_wr) begin
               if (r_is_b) r_b_rdata <= w_rd_word;
               else        r_a_rdata <= w_rd_word;
            end
         end
      end
   end

   assign bus.a_ready   = r_a_ready;
   assign bus.a_rdata   = r_a_rdata;
   assign bus.a_stall   = bus.a_req & ~r_a_ready;
   assign bus.b_ready   = r_b_ready;
   assign bus.b_rdata   = r_b_rdata;
   assign bus.mem_addr  = w_mem_addr;
   assign bus.mem_wdata = w_mem_wdata;
   assign bus.mem_we    = w_mem_we;
   assign bus.mem_re    = w_mem_re;

endmodule

// File: tb/tb_mem_access_controller.sv
// Bench for mem_access_controller: byte-wide memory device, per-port
// expected-response queues filled at issue time, and a monitor that checks
// every completion (memory accesses, latency, read data).
module tb_mem_access_controller;
   import mem_ctrl_pkg::*;

   typedef struct {
      bit          is_b;
      bit          wr;
      bit          word;
      logic [15:0] addr;
      logic [15:0] wdata;
      logic [15:0] rdata;
   } exp_t;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   mem_access_controller_if #(.ADDR_W(16)) bus_if ();

   mem_access_controller #(
      .ADDR_W      (16),
      .STARVE_LIMIT(4)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus_if)
   );

   bit [7:0] dev_mem [0:65535];
   bit [7:0] ref_mem [0:65535];
   exp_t     a_q[$];
   exp_t     b_q[$];
   bit       grant_log[$];
   int       n_chk = 0;
   int       n_err = 0;
   int       cyc   = 0;
   int       n_acc;
   int       t_start;
   logic [15:0] acc_addr [2];
   logic [7:0]  acc_wd   [2];
   logic        acc_we   [2];

   // byte-wide memory with registered read data
   always @(posedge clk) begin
      if (bus_if.mem_we) dev_mem[bus_if.mem_addr] <= bus_if.mem_wdata;
      if (bus_if.mem_re) bus_if.mem_rdata <= dev_mem[bus_if.mem_addr];
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, req);
      end
   endtask

   // reference model: apply writes to ref_mem, compute read results
   task automatic push_exp(input bit is_b, input bit wr, input logic [1:0] nb,
                           input logic [15:0] addr, input logic [15:0] wdata);
      exp_t e;
      logic [15:0] a1;
      a1      = addr + 16'd1;
      e.is_b  = is_b;
      e.wr    = wr;
      e.word  = is_b ? 1'b1 : (nb != NB_BYTE);
      e.addr  = addr;
      e.wdata = wdata;
      e.rdata = 16'h0;
      if (wr) begin
         ref_mem[addr] = wdata[7:0];
         if (e.word) ref_mem[a1] = wdata[15:8];
      end else begin
         e.rdata = e.word ? {ref_mem[a1], ref_mem[addr]} : {8'h00, ref_mem[addr]};
      end
      if (is_b) b_q.push_back(e);
      else      a_q.push_back(e);
   endtask

   task automatic wait_ready(input bit is_b);
      bit seen;
      seen = 1'b0;
      for (int c = 0; c < 100 && !seen; c++) begin
         @(negedge clk);
         seen = is_b ? bus_if.b_ready : bus_if.a_ready;
      end
      if (!seen) chk(is_b ? "b_ready_timeout" : "a_ready_timeout", 0, 1);
   endtask

   task automatic a_op(input bit wr, input logic [1:0] nb, input logic [15:0] addr,
                       input logic [15:0] wdata);
      push_exp(1'b0, wr, nb, addr, wdata);
      bus_if.a_wr     = wr;
      bus_if.a_nbytes = nb;
      bus_if.a_addr   = addr;
      bus_if.a_wdata  = wdata;
      bus_if.a_req    = 1'b1;
      wait_ready(1'b0);
      bus_if.a_req    = 1'b0;
   endtask

   task automatic b_op(input bit wr, input logic [15:0] addr, input logic [15:0] wdata);
      push_exp(1'b1, wr, NB_WORD, addr, wdata);
      bus_if.b_wr    = wr;
      bus_if.b_addr  = addr;
      bus_if.b_wdata = wdata;
      bus_if.b_req   = 1'b1;
      wait_ready(1'b1);
      bus_if.b_req   = 1'b0;
   endtask

   // monitor: record memory accesses, check each completion against its queue
   initial begin
      exp_t        e;
      bit          port;
      bit          empty;
      logic        s;
      logic [15:0] a1;
      n_acc   = 0;
      t_start = 0;
      forever begin
         @(negedge clk);
         cyc++;
         if (reset) begin
            n_acc = 0;
            continue;
         end
         s = bus_if.a_req & ~bus_if.a_ready;
         chk("a_stall", bus_if.a_stall, s);
         if (bus_if.mem_we | bus_if.mem_re) begin
            if (n_acc == 0) t_start = cyc;
            if (n_acc < 2) begin
               acc_addr[n_acc] = bus_if.mem_addr;
               acc_wd[n_acc]   = bus_if.mem_wdata;
               acc_we[n_acc]   = bus_if.mem_we;
            end
            n_acc++;
         end
         if (bus_if.a_ready && bus_if.b_ready) begin
            chk("single_ready", 1, 0);
            n_acc = 0;
         end else if (bus_if.a_ready || bus_if.b_ready) begin
            port = bus_if.b_ready;
            grant_log.push_back(port);
            empty = port ? (b_q.size() == 0) : (a_q.size() == 0);
            if (empty) begin
               chk(port ? "b_ready_expected" : "a_ready_expected", 0, 1);
            end else begin
               e  = port ? b_q.pop_front() : a_q.pop_front();
               a1 = e.addr + 16'd1;
               chk("access_count", n_acc, e.word ? 2 : 1);
               chk("latency", cyc - t_start + 1, e.word ? 4 : 3);
               chk("addr_lo", acc_addr[0], e.addr);
               chk("we_lo", acc_we[0], e.wr);
               if (e.word) begin
                  chk("addr_hi", acc_addr[1], a1);
                  chk("we_hi", acc_we[1], e.wr);
               end
               if (e.wr) begin
                  chk("wdata_lo", acc_wd[0], e.wdata[7:0]);
                  if (e.word) chk("wdata_hi", acc_wd[1], e.wdata[15:8]);
               end else if (port) begin
                  chk("b_rdata", bus_if.b_rdata, e.rdata);
               end else begin
                  chk("a_rdata", bus_if.a_rdata, e.rdata);
               end
            end
            n_acc = 0;
         end
      end
   end

   // stimulus
   initial begin
      bit exp_order[$];
      int waits;
      int n_done;
      bit hit;

      bus_if.a_req = 1'b0; bus_if.a_wr = 1'b0; bus_if.a_nbytes = 2'b00;
      bus_if.a_addr = '0;  bus_if.a_wdata = '0;
      bus_if.b_req = 1'b0; bus_if.b_wr = 1'b0; bus_if.b_addr = '0; bus_if.b_wdata = '0;

      // reset state
      repeat (3) @(negedge clk);
      chk("rst_a_ready", bus_if.a_ready, 0);
      chk("rst_b_ready", bus_if.b_ready, 0);
      chk("rst_a_rdata", bus_if.a_rdata, 0);
      chk("rst_b_rdata", bus_if.b_rdata, 0);
      chk("rst_mem_we", bus_if.mem_we, 0);
      chk("rst_mem_re", bus_if.mem_re, 0);
      chk("rst_mem_addr", bus_if.mem_addr, 0);
      chk("rst_mem_wdata", bus_if.mem_wdata, 0);

      // word write issued as reset releases: granted at the very next edge
      reset = 1'b0;
      push_exp(1'b0, 1'b1, NB_WORD, 16'h0010, 16'hBEEF);
      bus_if.a_wr = 1'b1; bus_if.a_nbytes = NB_WORD;
      bus_if.a_addr = 16'h0010; bus_if.a_wdata = 16'hBEEF;
      bus_if.a_req = 1'b1;
      @(negedge clk);
      chk("first_grant_we", bus_if.mem_we, 1);
      chk("first_grant_addr", bus_if.mem_addr, 16'h0010);
      chk("first_grant_wdata", bus_if.mem_wdata, 8'hEF);
      wait_ready(1'b0);
      bus_if.a_req = 1'b0;

      // read back: word, then byte with zero extension
      a_op(1'b0, NB_WORD, 16'h0010, 16'h0);
      a_op(1'b0, NB_BYTE, 16'h0011, 16'h0);
      // word at the top of the address space wraps to 0x0000
      a_op(1'b1, 2'b11, 16'hFFFF, 16'h1234);
      a_op(1'b0, 2'b00, 16'hFFFF, 16'h0);

      // B traffic leaves the A read data untouched
      b_op(1'b1, 16'h8000, 16'hA5C3);
      b_op(1'b0, 16'h8000, 16'h0);
      chk("a_rdata_hold", bus_if.a_rdata, 16'h1234);

      // both requesters held high from the same cycle
      waits = 0;
      for (int i = 0; i < 10; i++) begin
         if (waits == 4) begin exp_order.push_back(1'b1); waits = 0; end
         else            begin exp_order.push_back(1'b0); waits++;   end
      end
      foreach (exp_order[i]) push_exp(exp_order[i], 1'b0, NB_WORD,
                                      exp_order[i] ? 16'h8000 : 16'h0010, 16'h0);
      grant_log.delete();
      bus_if.a_wr = 1'b0; bus_if.a_nbytes = NB_WORD; bus_if.a_addr = 16'h0010;
      bus_if.b_wr = 1'b0; bus_if.b_addr = 16'h8000;
      bus_if.a_req = 1'b1; bus_if.b_req = 1'b1;
      n_done = 0;
      for (int c = 0; c < 200 && n_done < 10; c++) begin
         @(negedge clk);
         if (bus_if.a_ready || bus_if.b_ready) n_done++;
      end
      bus_if.a_req = 1'b0; bus_if.b_req = 1'b0;
      chk("order_completions", n_done, 10);
      @(negedge clk);
      if (grant_log.size() >= 10) begin
         for (int i = 0; i < 10; i++)
            chk($sformatf("grant_order[%0d]", i), grant_log[i], exp_order[i]);
      end else begin
         chk("grant_log_size", grant_log.size(), 10);
      end

      // reset during the second byte of a B write aborts it cleanly
      bus_if.b_wr = 1'b1; bus_if.b_addr = 16'h8100; bus_if.b_wdata = 16'hCAFE;
      bus_if.b_req = 1'b1;
      hit = 1'b0;
      for (int c = 0; c < 50 && !hit; c++) begin
         @(negedge clk);
         hit = bus_if.mem_we && (bus_if.mem_addr == 16'h8101);
      end
      chk("abort_reached_acc1", hit, 1);
      reset = 1'b1;
      bus_if.b_req = 1'b0;
      @(negedge clk);
      chk("abort_mem_we", bus_if.mem_we, 0);
      chk("abort_mem_re", bus_if.mem_re, 0);
      chk("abort_mem_addr", bus_if.mem_addr, 0);
      chk("abort_mem_wdata", bus_if.mem_wdata, 0);
      chk("abort_b_ready", bus_if.b_ready, 0);
      chk("abort_b_rdata", bus_if.b_rdata, 0);
      chk("abort_a_rdata", bus_if.a_rdata, 0);
      reset = 1'b0;
      repeat (4) begin
         @(negedge clk);
         chk("post_abort_quiet", {bus_if.mem_we, bus_if.mem_re, bus_if.b_ready}, 3'b000);
      end
      b_op(1'b1, 16'h8100, 16'h1357);
      b_op(1'b0, 16'h8100, 16'h0);

      // randomized concurrent traffic in disjoint address regions
      fork
         begin
            for (int i = 0; i < 30; i++) begin
               repeat ($urandom_range(0, 3)) @(negedge clk);
               a_op(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                    16'($urandom_range(0, 255)), 16'($urandom));
            end
         end
         begin
            for (int i = 0; i < 30; i++) begin
               repeat ($urandom_range(0, 3)) @(negedge clk);
               b_op(1'($urandom_range(0, 1)), 16'h8000 + 16'($urandom_range(0, 254)),
                    16'($urandom));
            end
         end
      join
      repeat (5) @(negedge clk);
      chk("a_queue_drained", a_q.size(), 0);
      chk("b_queue_drained", b_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
      $fatal(1);
   end

endmodule
